// File: rtl/sensor_arb_pkg.sv
// sensor_arb_pkg
//   Shared types and constants for the sensor event arbiter:
//   - state_t   : offer FSM states (S_IDLE, S_OFFER)
//   - EVT_PRESS : evt_long value for a press (rising edge) event
//   - EVT_LONG  : evt_long value for a long-hold event
package sensor_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    localparam logic EVT_PRESS = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

endpackage

// File: rtl/sensor_hold_tracker.sv
// sensor_hold_tracker
//   Per-sensor edge detector and hold counter.
//   Optional feature macro: SENSOR_LONG_PRESS_EN (hold counter present only
//   when defined; otherwise long_pulse is constant 0).
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     lvl          : debounced sensor level
//     press_pulse  : 1 in the cycle the level is high and was low last cycle
//     long_pulse   : 1 in the cycle whose edge brings the hold count to HOLD_CYCLES
module sensor_hold_tracker #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic lvl,
    output logic press_pulse,
    output logic long_pulse
);

    logic prev_q, prev_d;

    always_comb begin
        prev_d      = lvl;
        press_pulse = lvl & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= prev_d;
    end

`ifdef SENSOR_LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [HW-1:0] hcnt_q, hcnt_d;

    // Counter saturates at HOLD_CYCLES, so the long pulse fires exactly once
    // per continuous high period.
    always_comb begin
        hcnt_d     = hcnt_q;
        long_pulse = 1'b0;
        if (!lvl) begin
            hcnt_d = '0;
        end else if (hcnt_q != HW'(HOLD_CYCLES)) begin
            hcnt_d     = hcnt_q + 1'b1;
            long_pulse = (hcnt_q == HW'(HOLD_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hcnt_q <= '0;
        else       hcnt_q <= hcnt_d;
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/sensor_event_arbiter.sv
// sensor_event_arbiter
//   Turns debounced sensor levels into a serialized stream of press and
//   long-hold events, one pending event of each kind per sensor, granted
//   round-robin over a registered valid/ready handshake.
//   Optional feature macro: SENSOR_LONG_PRESS_EN (long-hold events).
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     sensor_lvl  : debounced levels, one per sensor
//     evt_ready   : consumer accepts when evt_valid && evt_ready
//     evt_valid   : event register holds an event
//     evt_id      : sensor index of the offered event
//     evt_long    : 1 = long-hold event, 0 = press event
//     pending     : per-sensor OR of short and long pending bits
//     overrun     : sticky, an event was merged into an already-pending one
module sensor_event_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int N_SENS      = 4,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SENS-1:0]         sensor_lvl,
    input  logic                      evt_ready,
    output logic                      evt_valid,
    output logic [$clog2(N_SENS)-1:0] evt_id,
    output logic                      evt_long,
    output logic [N_SENS-1:0]         pending,
    output logic                      overrun
);

    localparam int IDW = $clog2(N_SENS);

    logic [N_SENS-1:0] press_pulse;
    logic [N_SENS-1:0] short_pend_q, short_pend_d;
    logic [N_SENS-1:0] long_pend;
    logic              overrun_q, overrun_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    evt_id_q, evt_id_d;
    logic              evt_long_q, evt_long_d;
    state_t            state_q, state_d;

    logic              gnt_found;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_long;
    logic              do_grant;
    logic              ov_short;

`ifdef SENSOR_LONG_PRESS_EN
    logic [N_SENS-1:0] long_pulse;
    logic [N_SENS-1:0] long_pend_q, long_pend_d;
    logic              ov_long;
    assign long_pend = long_pend_q;
`else
    assign long_pend = '0;
`endif

    for (genvar i = 0; i < N_SENS; i++) begin : g_trk
        sensor_hold_tracker #(.HOLD_CYCLES(HOLD_CYCLES)) u_trk (
            .clk         (clk),
            .reset       (reset),
            .lvl         (sensor_lvl[i]),
            .press_pulse (press_pulse[i]),
`ifdef SENSOR_LONG_PRESS_EN
            .long_pulse  (long_pulse[i])
`else
            .long_pulse  ()
`endif
        );
    end

    // Round-robin search from rr_ptr over sensors with anything pending;
    // a sensor's press is served before its long-hold.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_long  = EVT_PRESS;
        for (int off = 0; off < N_SENS; off++) begin
            cand = (int'(rr_ptr_q) + off) % N_SENS;
            if (!gnt_found && (short_pend_q[cand] || long_pend[cand])) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
                gnt_long  = short_pend_q[cand] ? EVT_PRESS : EVT_LONG;
            end
        end
    end

    // Offer FSM: a new winner loads whenever the event register is empty or
    // being accepted this edge.
    always_comb begin
        state_d    = state_q;
        evt_id_d   = evt_id_q;
        evt_long_d = evt_long_q;
        rr_ptr_d   = rr_ptr_q;
        do_grant   = 1'b0;
        case (state_q)
            S_IDLE:  do_grant = gnt_found;
            S_OFFER: begin
                if (evt_ready) begin
                    do_grant = gnt_found;
                    if (!gnt_found) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_grant) begin
            state_d    = S_OFFER;
            evt_id_d   = gnt_idx;
            evt_long_d = gnt_long;
            rr_ptr_d   = (gnt_idx == IDW'(N_SENS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pending bits: a new set beats a same-cycle grant clear; a set landing
    // on a bit that stays set is an overrun.
    always_comb begin
        logic clr;
        ov_short = 1'b0;
        for (int i = 0; i < N_SENS; i++) begin
            clr             = do_grant && (gnt_idx == IDW'(i)) && (gnt_long == EVT_PRESS);
            short_pend_d[i] = press_pulse[i] | (short_pend_q[i] & ~clr);
            ov_short        = ov_short | (press_pulse[i] & short_pend_q[i] & ~clr);
        end
    end

`ifdef SENSOR_LONG_PRESS_EN
    always_comb begin
        logic clr;
        ov_long = 1'b0;
        for (int i = 0; i < N_SENS; i++) begin
            clr            = do_grant && (gnt_idx == IDW'(i)) && (gnt_long == EVT_LONG);
            long_pend_d[i] = long_pulse[i] | (long_pend_q[i] & ~clr);
            ov_long        = ov_long | (long_pulse[i] & long_pend_q[i] & ~clr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) long_pend_q <= '0;
        else       long_pend_q <= long_pend_d;
    end

    assign overrun_d = overrun_q | ov_short | ov_long;
`else
    assign overrun_d = overrun_q | ov_short;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            evt_id_q     <= '0;
            evt_long_q   <= EVT_PRESS;
            rr_ptr_q     <= '0;
            short_pend_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            evt_id_q     <= evt_id_d;
            evt_long_q   <= evt_long_d;
            rr_ptr_q     <= rr_ptr_d;
            short_pend_q <= short_pend_d;
            overrun_q    <= overrun_d;
        end
    end

    assign evt_valid = (state_q == S_OFFER);
    assign evt_id    = evt_id_q;
    assign evt_long  = evt_long_q;
    assign pending   = short_pend_q | long_pend;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sensor_event_arbiter.sv
// tb_sensor_event_arbiter
//   Directed self-checking bench for sensor_event_arbiter (N_SENS=4,
//   HOLD_CYCLES=10). Long-hold scenario runs when SENSOR_LONG_PRESS_EN is
//   defined, the press-only scenario otherwise.
module tb_sensor_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sensor_lvl;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_long;
    logic [3:0] pending;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    sensor_event_arbiter #(.N_SENS(4), .HOLD_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_lvl (sensor_lvl),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_long   (evt_long),
        .pending    (pending),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled and inputs driven 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sensor_lvl = 4'b0000;
        evt_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({evt_valid, evt_id, evt_long, pending, overrun} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b id=%0d long=%b pend=%b ovr=%b, want all 0",
                     evt_valid, evt_id, evt_long, pending, overrun);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        evt_ready  = 1'b1;
        sensor_lvl = 4'b0100;
        tick();  // edge 1: short_pend[2] set
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL press_edge1: got valid=%b pend=%b, want valid=0 pend=0100", evt_valid, pending);
        end
        tick();  // edge 2: offered
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_long !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL press_offer: got valid=%b id=%0d long=%b pend=%b, want 1 2 0 0000",
                     evt_valid, evt_id, evt_long, pending);
        end
        tick();  // edge 3: accepted, nothing left
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_single: got valid=%b after accept, want 0", evt_valid);
        end
        sensor_lvl = 4'b0000;
        tick();
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL press_quiet: got valid=%b pend=%b ovr=%b, want 0 0000 0", evt_valid, pending, overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        evt_ready  = 1'b1;
        sensor_lvl = 4'b1111;
        tick();  // all four set
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'(k) || evt_long !== 1'b0) begin
                errors++;
                $display("FAIL b2b_evt%0d: got valid=%b id=%0d long=%b, want 1 %0d 0",
                         k, evt_valid, evt_id, evt_long, k);
            end
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b pend=%b, want 0 0000", evt_valid, pending);
        end
        sensor_lvl = 4'b0000;
        tick();
    endtask

    // Three rises of sensor 0 with no consumer: first is offered and held,
    // second sits pending, third merges into it.
    task automatic test_overrun();
        do_reset();
        evt_ready = 1'b0;
        sensor_lvl = 4'b0001; tick();
        sensor_lvl = 4'b0000; tick();
        sensor_lvl = 4'b0001; tick();
        checks++;
        if (overrun !== 1'b0 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL ovr_second: got ovr=%b pend=%b, want 0 0001", overrun, pending);
        end
        sensor_lvl = 4'b0000; tick();
        sensor_lvl = 4'b0001; tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_long !== 1'b0 ||
            pending !== 4'b0001 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold: got valid=%b id=%0d long=%b pend=%b ovr=%b, want 1 0 0 0001 1",
                     evt_valid, evt_id, evt_long, pending, overrun);
        end
        sensor_lvl = 4'b0000;
        evt_ready  = 1'b1;
        tick();  // held event accepted, pending one loaded
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL ovr_next: got valid=%b id=%0d pend=%b, want 1 0 0000", evt_valid, evt_id, pending);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drain: got valid=%b ovr=%b, want 0 1", evt_valid, overrun);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        evt_ready  = 1'b0;
        sensor_lvl = 4'b0001; tick();  // sensor 0 pending
        sensor_lvl = 4'b1010; tick();  // sensor 0 offered, 1 and 3 pending
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || pending !== 4'b1010) begin
            errors++;
            $display("FAIL rst_pre: got valid=%b id=%0d pend=%b, want 1 0 1010", evt_valid, evt_id, pending);
        end
        sensor_lvl = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000 || overrun !== 1'b0 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: got valid=%b pend=%b ovr=%b id=%0d, want 0 0000 0 0",
                     evt_valid, pending, overrun, evt_id);
        end
        evt_ready  = 1'b1;
        sensor_lvl = 4'b1000; tick();
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_long !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got valid=%b id=%0d long=%b, want 1 3 0", evt_valid, evt_id, evt_long);
        end
        sensor_lvl = 4'b0000;
        tick();
    endtask

    // Sensor held high; record which edges produce an offered event.
    task automatic run_hold(input logic [3:0] lvl, input int hold_edges, input int total_edges,
                            input int exp_press_edge, input int exp_long_edge, input logic [1:0] exp_id,
                            input string name);
        do_reset();
        evt_ready  = 1'b1;
        sensor_lvl = lvl;
        for (int n = 1; n <= total_edges; n++) begin
            tick();
            if (n == hold_edges) sensor_lvl = 4'b0000;
            checks++;
            if (n == exp_press_edge) begin
                if (evt_valid !== 1'b1 || evt_id !== exp_id || evt_long !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_press: edge %0d got valid=%b id=%0d long=%b, want 1 %0d 0",
                             name, n, evt_valid, evt_id, evt_long, exp_id);
                end
            end else if (n == exp_long_edge) begin
                if (evt_valid !== 1'b1 || evt_id !== exp_id || evt_long !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_long: edge %0d got valid=%b id=%0d long=%b, want 1 %0d 1",
                             name, n, evt_valid, evt_id, evt_long, exp_id);
                end
            end else if (evt_valid !== 1'b0 || evt_long !== 1'b0 && evt_valid === 1'b1) begin
                errors++;
                $display("FAIL %s_quiet: edge %0d got valid=%b long=%b, want valid=0",
                         name, n, evt_valid, evt_long);
            end
        end
    endtask

`ifdef SENSOR_LONG_PRESS_EN
    task automatic test_long_press();
        // press offered after edge 2; long set on 10th high edge, offered after edge 11
        run_hold(4'b0010, 12, 16, 2, 11, 2'd1, "long");
    endtask
`else
    task automatic test_no_long();
        run_hold(4'b0100, 20, 24, 2, -1, 2'd2, "nolong");
    endtask
`endif

    initial begin
        reset      = 1'b1;
        sensor_lvl = 4'b0000;
        evt_ready  = 1'b0;
        test_reset();
        test_single_press();
        test_back_to_back();
        test_overrun();
        test_reset_mid_offer();
`ifdef SENSOR_LONG_PRESS_EN
        test_long_press();
`else
        test_no_long();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
